l2_req_arbiter: RTL

Shares the single next-level (L2) cache port between the instruction-cache miss path and the data-cache miss path. Each requester hands over a 26-bit line address through a one-entry holding register. The arbiter picks one pending request by round-robin and drives a single outstanding L2 transaction under a req/ack handshake. It signals completion back to the originating cache and keeps grant and contention statistics for the statistics module.

---
 rtl/l2_req_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: shares one L2 request port between the instruction and data
// miss paths. Each source has a one-entry holding register, and sources are granted round-robin.
module l2_req_arbiter #(
    parameter int unsigned ADDR_W = 26,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_op,
    output logic              d_ready,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [1:0]        l2_op,
    output logic              l2_src,
    input  logic              l2_ack,
    output logic              i_done,
    output logic              d_done,
    output logic [CNT_W-1:0]  i_grants,
    output logic [CNT_W-1:0]  d_grants,
    output logic [CNT_W-1:0]  conflicts
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              rr_q, rr_d;
    logic              ih_v_q, ih_v_d;
    logic [ADDR_W-1:0] ih_a_q, ih_a_d;
    logic              dh_v_q, dh_v_d;
    logic [ADDR_W-1:0] dh_a_q, dh_a_d;
    logic [1:0]        dh_op_q, dh_op_d;
    logic              l2_req_q, l2_req_d;
    logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
    logic [1:0]        l2_op_q, l2_op_d;
    logic              l2_src_q, l2_src_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic [CNT_W-1:0]  ig_q, ig_d;
    logic [CNT_W-1:0]  dg_q, dg_d;
    logic [CNT_W-1:0]  cf_q, cf_d;
    logic              both;
    logic              win;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        ih_v_d    = ih_v_q;
        ih_a_d    = ih_a_q;
        dh_v_d    = dh_v_q;
        dh_a_d    = dh_a_q;
        dh_op_d   = dh_op_q;
        l2_req_d  = l2_req_q;
        l2_addr_d = l2_addr_q;
        l2_op_d   = l2_op_q;
        l2_src_d  = l2_src_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        ig_d      = ig_q;
        dg_d      = dg_q;
        cf_d      = cf_q;
        both      = ih_v_q && dh_v_q;
        // On a tie rr_q names the winner; otherwise the only pending source wins
        win       = both ? rr_q : dh_v_q;

        if (i_valid && !ih_v_q) begin
            ih_v_d = 1'b1;
            ih_a_d = i_addr;
        end
        if (d_valid && !dh_v_q) begin
            dh_v_d  = 1'b1;
            dh_a_d  = d_addr;
            dh_op_d = d_op;
        end

        case (state_q)
            ST_IDLE: begin
                if (ih_v_q || dh_v_q) begin
                    state_d   = ST_BUSY;
                    l2_req_d  = 1'b1;
                    l2_src_d  = win;
                    l2_addr_d = win ? dh_a_q : ih_a_q;
                    l2_op_d   = win ? dh_op_q : 2'b00;
                    rr_d      = ~win;
                    if (win) dg_d = dg_q + CNT_W'(1);
                    else     ig_d = ig_q + CNT_W'(1);
                    if (both) cf_d = cf_q + CNT_W'(1);
                end
            end
            default: begin
                // Clearing never collides with an accept: ready is low while held
                if (l2_ack) begin
                    state_d  = ST_IDLE;
                    l2_req_d = 1'b0;
                    if (l2_src_q) begin
                        d_done_d = 1'b1;
                        dh_v_d   = 1'b0;
                    end else begin
                        i_done_d = 1'b1;
                        ih_v_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            ih_v_q    <= 1'b0;
            ih_a_q    <= '0;
            dh_v_q    <= 1'b0;
            dh_a_q    <= '0;
            dh_op_q   <= '0;
            l2_req_q  <= 1'b0;
            l2_addr_q <= '0;
            l2_op_q   <= '0;
            l2_src_q  <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            ig_q      <= '0;
            dg_q      <= '0;
            cf_q      <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            ih_v_q    <= ih_v_d;
            ih_a_q    <= ih_a_d;
            dh_v_q    <= dh_v_d;
            dh_a_q    <= dh_a_d;
            dh_op_q   <= dh_op_d;
            l2_req_q  <= l2_req_d;
            l2_addr_q <= l2_addr_d;
            l2_op_q   <= l2_op_d;
            l2_src_q  <= l2_src_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            ig_q      <= ig_d;
            dg_q      <= dg_d;
            cf_q      <= cf_d;
        end
    end

    assign i_ready   = !ih_v_q;
    assign d_ready   = !dh_v_q;
    assign l2_req    = l2_req_q;
    assign l2_addr   = l2_addr_q;
    assign l2_op     = l2_op_q;
    assign l2_src    = l2_src_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_grants  = ig_q;
    assign d_grants  = dg_q;
    assign conflicts = cf_q;

endmodule
